// File: rtl/apb_manager_arbiter.sv
// Round-robin arbiter and APB SETUP/ACCESS sequencer sharing one bus among NumReq requesters.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer; pick next requester at or after rr_ptr
// SETUP  | busSel asserted, address/control driven, busEnable low
// ACCESS | busEnable high, waiting for busReady (or watchdog)
module apb_manager_arbiter #(
    parameter int NumReq        = 4,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int PrphNum       = 8,
    parameter int TimeoutCycles = 16
) (
    input  logic                          clk,
    input  logic                          nReset,
    input  logic [NumReq-1:0]             reqValid,
    input  logic [NumReq-1:0]             reqWrite,
    input  logic [NumReq*AddrWidth-1:0]   reqAddr,
    input  logic [NumReq*DataWidth-1:0]   reqWData,
    input  logic [NumReq*3-1:0]           reqProt,
    output logic [NumReq-1:0]             reqDone,
    output logic [DataWidth-1:0]          reqRData,
    output logic                          reqError,
    output logic [PrphNum-1:0]            busSel,
    output logic                          busEnable,
    output logic                          busWrite,
    output logic [AddrWidth-1:0]          busAddr,
    output logic [DataWidth-1:0]          busWData,
    output logic [2:0]                    busProt,
    input  logic                          busReady,
    input  logic [DataWidth-1:0]          busRData,
    input  logic                          busSubError
);

    localparam int GntW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int SelW = $clog2(PrphNum);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]           state;
    logic [GntW-1:0]      rr_ptr;
    logic [GntW-1:0]      grant;
    logic [GntW-1:0]      next_grant;
    logic                 any_valid;
    logic [AddrWidth-1:0] next_addr;
    logic [SelW-1:0]      sel_idx;
    logic                 timeout_hit;
    logic                 complete;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        logic [GntW-1:0] idx;
        idx        = '0;
        next_grant = rr_ptr;
        any_valid  = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = GntW'((int'(rr_ptr) + k) % NumReq);
            if (reqValid[idx]) begin
                next_grant = idx;
                any_valid  = 1'b1;
            end
        end
    end

    assign next_addr = reqAddr[next_grant*AddrWidth +: AddrWidth];
    assign sel_idx   = next_addr[AddrWidth-1 -: SelW];

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles) + 1;

    logic [CntW-1:0] wait_cnt;

    assign timeout_hit = (state == ST_ACCESS) && !busReady
                         && (wait_cnt == CntW'(TimeoutCycles));

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE && any_valid) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !busReady && !timeout_hit) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign complete = (state == ST_ACCESS) && (busReady || timeout_hit);
    assign reqDone  = complete ? (NumReq'(1) << grant) : '0;
    // Gate read data so it is never X outside completion, and zero on a watchdog abort.
    assign reqRData = (complete && !timeout_hit) ? busRData : '0;
    assign reqError = complete && (busSubError || timeout_hit);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            busSel    <= '0;
            busEnable <= 1'b0;
            busWrite  <= 1'b0;
            busAddr   <= '0;
            busWData  <= '0;
            busProt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        state    <= ST_SETUP;
                        grant    <= next_grant;
                        busWrite <= reqWrite[next_grant];
                        busAddr  <= next_addr;
                        busWData <= reqWData[next_grant*DataWidth +: DataWidth];
                        busProt  <= reqProt[next_grant*3 +: 3];
                        busSel   <= PrphNum'(1) << sel_idx;
                    end
                end
                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    busEnable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (complete) begin
                        state     <= ST_IDLE;
                        busSel    <= '0;
                        busEnable <= 1'b0;
                        rr_ptr    <= GntW'((int'(grant) + 1) % NumReq);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_manager_arbiter.sv
// Scoreboard bench for apb_manager_arbiter: stimulus queues expected completions, a negedge monitor checks them.
module tb_apb_manager_arbiter;

    logic         clk = 1'b0;
    logic         nReset;
    logic [3:0]   reqValid;
    logic [3:0]   reqWrite;
    logic [127:0] reqAddr;
    logic [127:0] reqWData;
    logic [11:0]  reqProt;
    logic [3:0]   reqDone;
    logic [31:0]  reqRData;
    logic         reqError;
    logic [7:0]   busSel;
    logic         busEnable;
    logic         busWrite;
    logic [31:0]  busAddr;
    logic [31:0]  busWData;
    logic [2:0]   busProt;
    logic         busReady;
    logic [31:0]  busRData;
    logic         busSubError;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  done;
        logic [31:0] rdata;
        logic        err;
        int          dcyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [2:0]  prot;
        logic [7:0]  sel;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] f_addr [4];
    logic [31:0] f_wdata[4];

    apb_manager_arbiter dut (
        .clk        (clk),
        .nReset     (nReset),
        .reqValid   (reqValid),
        .reqWrite   (reqWrite),
        .reqAddr    (reqAddr),
        .reqWData   (reqWData),
        .reqProt    (reqProt),
        .reqDone    (reqDone),
        .reqRData   (reqRData),
        .reqError   (reqError),
        .busSel     (busSel),
        .busEnable  (busEnable),
        .busWrite   (busWrite),
        .busAddr    (busAddr),
        .busWData   (busWData),
        .busProt    (busProt),
        .busReady   (busReady),
        .busRData   (busRData),
        .busSubError(busSubError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] p);
        reqValid[i]          = 1'b1;
        reqWrite[i]          = wr;
        reqAddr[i*32 +: 32]  = a;
        reqWData[i*32 +: 32] = wd;
        reqProt[i*3 +: 3]    = p;
    endtask

    task automatic push_exp(input int g, input logic [31:0] a, input logic [31:0] wd,
                            input logic wr, input logic [2:0] p, input logic [31:0] rd,
                            input logic err, input int dcyc);
        exp_t e;
        e.done  = 4'(1) << g;
        e.rdata = rd;
        e.err   = err;
        e.dcyc  = dcyc;
        e.addr  = a;
        e.wdata = wd;
        e.wr    = wr;
        e.prot  = p;
        e.sel   = 8'(1) << a[31:29];
        exp_q.push_back(e);
    endtask

    // Monitor: every completion strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reqDone != 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(reqDone), 64'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_vec",   64'(reqDone),   64'(e.done));
                chk("done_cycle", 64'(cyc),       64'(e.dcyc));
                chk("rdata",      64'(reqRData),  64'(e.rdata));
                chk("error",      64'(reqError),  64'(e.err));
                chk("bus_addr",   64'(busAddr),   64'(e.addr));
                chk("bus_wdata",  64'(busWData),  64'(e.wdata));
                chk("bus_write",  64'(busWrite),  64'(e.wr));
                chk("bus_prot",   64'(busProt),   64'(e.prot));
                chk("bus_sel",    64'(busSel),    64'(e.sel));
                chk("bus_enable", 64'(busEnable), 64'h1);
            end
        end
    end

    initial begin
        f_addr[0]  = 32'h0000_0100; f_wdata[0] = 32'h1111_1111;
        f_addr[1]  = 32'h2000_0104; f_wdata[1] = 32'h2222_2222;
        f_addr[2]  = 32'h8000_0108; f_wdata[2] = 32'h3333_3333;
        f_addr[3]  = 32'hA000_010C; f_wdata[3] = 32'h4444_4444;

        nReset      = 1'b0;
        reqValid    = '0;
        reqWrite    = '0;
        reqAddr     = '0;
        reqWData    = '0;
        reqProt     = '0;
        busReady    = 1'b0;
        busRData    = '0;
        busSubError = 1'b0;

        #12;
        chk("rst_bus_sel",    64'(busSel),    64'h0);
        chk("rst_bus_enable", 64'(busEnable), 64'h0);
        chk("rst_req_done",   64'(reqDone),   64'h0);
        chk("rst_bus_addr",   64'(busAddr),   64'h0);
        chk("rst_bus_write",  64'(busWrite),  64'h0);
        chk("rst_rdata_known", 64'($isunknown(reqRData)), 64'h0);
        @(posedge clk); #2;
        nReset = 1'b1;

        // Single write, zero wait states
        @(posedge clk); #2;
        set_req(0, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 3'b010);
        busReady = 1'b1;
        push_exp(0, 32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 3'b010, 32'h0, 1'b0, cyc + 2);
        @(posedge clk);
        @(negedge clk);
        chk("w_c1_sel",    64'(busSel),    64'h04);
        chk("w_c1_enable", 64'(busEnable), 64'h0);
        @(posedge clk); #2;
        reqValid[0] = 1'b0;
        @(negedge clk);
        chk("w_c2_sel",    64'(busSel),    64'h04);
        chk("w_c2_enable", 64'(busEnable), 64'h1);
        @(negedge clk);
        chk("w_c3_sel",    64'(busSel),    64'h0);
        chk("w_c3_enable", 64'(busEnable), 64'h0);
        chk("w_c3_addr_held", 64'(busAddr), 64'h4000_0010);

        // Read from requester 2 with 3 wait states
        @(posedge clk); #2;
        busReady = 1'b0;
        busRData = 32'h1234_5678;
        set_req(2, 1'b0, 32'h6000_0020, 32'h0, 3'b001);
        push_exp(2, 32'h6000_0020, 32'h0, 1'b0, 3'b001, 32'h1234_5678, 1'b0, cyc + 5);
        @(posedge clk);
        @(negedge clk);
        chk("r_c1_sel",    64'(busSel),    64'h08);
        chk("r_c1_enable", 64'(busEnable), 64'h0);
        for (int k = 2; k <= 5; k++) begin
            @(posedge clk); #2;
            if (k == 5) busReady = 1'b1;
            @(negedge clk);
            chk("r_wait_sel",    64'(busSel),    64'h08);
            chk("r_wait_enable", 64'(busEnable), 64'h1);
            chk("r_wait_addr",   64'(busAddr),   64'h6000_0020);
            chk("r_wait_write",  64'(busWrite),  64'h0);
        end
        @(posedge clk); #2;
        reqValid[2] = 1'b0;

        // Requester 3 alone: top subordinate select and pointer wrap back to 0
        set_req(3, 1'b1, 32'hE000_0000, 32'h5A5A_A5A5, 3'b111);
        push_exp(3, 32'hE000_0000, 32'h5A5A_A5A5, 1'b1, 3'b111, 32'h1234_5678, 1'b0, cyc + 2);
        @(posedge clk);
        @(posedge clk); #2;
        reqValid[3] = 1'b0;
        @(posedge clk); #2;

        // Fairness: all four requesters continuously active for eight transfers
        busRData = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++)
            set_req(i, (i % 2) == 0, f_addr[i], f_wdata[i], 3'(i));
        for (int k = 0; k < 8; k++)
            push_exp(k % 4, f_addr[k % 4], f_wdata[k % 4], ((k % 4) % 2) == 0, 3'(k % 4),
                     32'hCAFE_F00D, 1'b0, cyc + 2 + 3 * k);
        repeat (24) @(posedge clk);
        #2;
        reqValid = '0;

        // Subordinate error, then a normal transfer
        set_req(1, 1'b0, 32'h4000_0000, 32'h0, 3'b000);
        busRData    = 32'hBAD0_0001;
        busSubError = 1'b1;
        push_exp(1, 32'h4000_0000, 32'h0, 1'b0, 3'b000, 32'hBAD0_0001, 1'b1, cyc + 2);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        reqValid[1] = 1'b0;
        busSubError = 1'b0;
        busRData    = 32'h0000_0777;
        set_req(2, 1'b1, 32'h2000_0040, 32'h0BAD_CAFE, 3'b100);
        push_exp(2, 32'h2000_0040, 32'h0BAD_CAFE, 1'b1, 3'b100, 32'h0000_0777, 1'b0, cyc + 2);
        @(posedge clk);
        @(posedge clk); #2;
        reqValid[2] = 1'b0;
        @(posedge clk); #2;

        // Asynchronous reset while ACCESS is stalled
        busReady = 1'b0;
        set_req(2, 1'b0, 32'h6000_0000, 32'h0, 3'b000);
        @(posedge clk);
        @(posedge clk); #3;
        chk("pre_rst_enable", 64'(busEnable), 64'h1);
        nReset = 1'b0;
        #1;
        chk("async_rst_sel",    64'(busSel),    64'h0);
        chk("async_rst_enable", 64'(busEnable), 64'h0);
        chk("async_rst_done",   64'(reqDone),   64'h0);
        reqValid[2] = 1'b0;
        @(posedge clk); #2;
        nReset = 1'b1;
        busReady = 1'b1;
        set_req(0, 1'b0, 32'h0000_0200, 32'h0, 3'b000);
        set_req(3, 1'b1, 32'hC000_0300, 32'h7777_0000, 3'b011);
        push_exp(0, 32'h0000_0200, 32'h0,          1'b0, 3'b000, 32'h0000_0777, 1'b0, cyc + 2);
        push_exp(3, 32'hC000_0300, 32'h7777_0000,  1'b1, 3'b011, 32'h0000_0777, 1'b0, cyc + 5);
        @(posedge clk);
        @(posedge clk); #2;
        reqValid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reqValid[3] = 1'b0;

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
